// File: rtl/vme_master_seq_if.sv
// rtl/vme_master_seq_if.sv - VME A24/D16 backplane signal bundle between master sequencer and slave/bus model
//
// master modport: drives address, AM, strobes, direction and write data;
//                 receives read data, DTACK and BERR.
// slave modport : the mirror image, for a backplane model or slave interface.
interface vme_master_seq_if;
    logic [22:0] vme_addr;
    logic [5:0]  vme_am;
    logic        vme_as_b;
    logic        vme_ds0_b;
    logic        vme_ds1_b;
    logic        vme_write_b;
    logic        vme_lword_b;
    logic [15:0] vme_data_out;
    logic        vme_data_oe;
    logic [15:0] vme_data_in;
    logic        vme_dtack_b;
    logic        vme_berr_b;

    modport master (
        output vme_addr, vme_am, vme_as_b, vme_ds0_b, vme_ds1_b, vme_write_b,
               vme_lword_b, vme_data_out, vme_data_oe,
        input  vme_data_in, vme_dtack_b, vme_berr_b
    );

    modport slave (
        input  vme_addr, vme_am, vme_as_b, vme_ds0_b, vme_ds1_b, vme_write_b,
               vme_lword_b, vme_data_out, vme_data_oe,
        output vme_data_in, vme_dtack_b, vme_berr_b
    );
endinterface

// File: rtl/vme_master_seq.sv
// rtl/vme_master_seq.sv - runs one A24/D16 VME master cycle per accepted command
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   start            command valid, only looked at while vme_cmd_rd=1
//   vme_cmd_reg      [25]=read, [24]=write ([25] wins), [23:1]=VME address
//   vme_dat_reg_in   [15:0] write data
//   vme_cmd_rd       level: ready for the next command
//   vme_dat_wr       one-cycle completion strobe
//   vme_dat_reg_out  {14'b0, berr, timeout, read data}, held until next completion
//   vme              backplane signals (master modport)
module vme_master_seq #(
    parameter logic [5:0] AM_CODE     = 6'h39,
    parameter int         SETUP_CYC   = 2,
    parameter int         DS_DLY      = 1,
    parameter int         TIMEOUT_CYC = 255,
    parameter int         RECOV_CYC   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      vme_cmd_reg,
    input  logic [31:0]      vme_dat_reg_in,
    output logic             vme_cmd_rd,
    output logic             vme_dat_wr,
    output logic [31:0]      vme_dat_reg_out,
    vme_master_seq_if.master vme
);
    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_ASSERT_AS, S_WAIT_ACK, S_RELEASE, S_DONE, S_RECOVER
    } state_t;

    // Counters hold "cycles spent so far", so each phase exits on value N-1.
    localparam logic [15:0] SETUP_LAST   = 16'(SETUP_CYC - 1);
    localparam logic [15:0] DS_LAST      = 16'(DS_DLY - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);
    localparam logic [15:0] RECOV_LAST   = 16'(RECOV_CYC - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        is_read_q, is_read_d;
    logic        timeout_q, timeout_d;
    logic        berr_q, berr_d;
    logic [15:0] rdata_q, rdata_d;
    logic        cmd_rd_q, cmd_rd_d;
    logic        dat_wr_q, dat_wr_d;
    logic [31:0] dat_out_q, dat_out_d;
    logic [22:0] addr_q, addr_d;
    logic [5:0]  am_q, am_d;
    logic        as_b_q, as_b_d;
    logic        ds_b_q, ds_b_d;
    logic        write_b_q, write_b_d;
    logic [15:0] dout_q, dout_d;
    logic        oe_q, oe_d;
    logic        dtack_meta_q, dtack_s_q, berr_meta_q, berr_s_q;
    logic        release_now, finish_now;
    logic        unused_bits;

    assign unused_bits = ^{vme_cmd_reg[31:26], vme_cmd_reg[0], vme_dat_reg_in[31:16]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            is_read_q    <= 1'b0;
            timeout_q    <= 1'b0;
            berr_q       <= 1'b0;
            rdata_q      <= '0;
            cmd_rd_q     <= 1'b0;
            dat_wr_q     <= 1'b0;
            dat_out_q    <= '0;
            addr_q       <= '0;
            am_q         <= '0;
            as_b_q       <= 1'b1;
            ds_b_q       <= 1'b1;
            write_b_q    <= 1'b1;
            dout_q       <= '0;
            oe_q         <= 1'b0;
            dtack_meta_q <= 1'b1;
            dtack_s_q    <= 1'b1;
            berr_meta_q  <= 1'b1;
            berr_s_q     <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            is_read_q    <= is_read_d;
            timeout_q    <= timeout_d;
            berr_q       <= berr_d;
            rdata_q      <= rdata_d;
            cmd_rd_q     <= cmd_rd_d;
            dat_wr_q     <= dat_wr_d;
            dat_out_q    <= dat_out_d;
            addr_q       <= addr_d;
            am_q         <= am_d;
            as_b_q       <= as_b_d;
            ds_b_q       <= ds_b_d;
            write_b_q    <= write_b_d;
            dout_q       <= dout_d;
            oe_q         <= oe_d;
            dtack_meta_q <= vme.vme_dtack_b;
            dtack_s_q    <= dtack_meta_q;
            berr_meta_q  <= vme.vme_berr_b;
            berr_s_q     <= berr_meta_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_read_d   = is_read_q;
        timeout_d   = timeout_q;
        berr_d      = berr_q;
        rdata_d     = rdata_q;
        dat_wr_d    = 1'b0;
        dat_out_d   = dat_out_q;
        addr_d      = addr_q;
        am_d        = am_q;
        as_b_d      = as_b_q;
        ds_b_d      = ds_b_q;
        write_b_d   = write_b_q;
        dout_d      = dout_q;
        oe_d        = oe_q;
        release_now = 1'b0;
        finish_now  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Address, AM and direction go onto the bus at the latch edge,
                // so the setup count starts right here.
                if (cmd_rd_q && start && (vme_cmd_reg[25] || vme_cmd_reg[24])) begin
                    is_read_d = vme_cmd_reg[25];
                    timeout_d = 1'b0;
                    berr_d    = 1'b0;
                    rdata_d   = '0;
                    cnt_d     = '0;
                    addr_d    = vme_cmd_reg[23:1];
                    am_d      = AM_CODE;
                    write_b_d = vme_cmd_reg[25];
                    dout_d    = vme_cmd_reg[25] ? 16'h0 : vme_dat_reg_in[15:0];
                    oe_d      = ~vme_cmd_reg[25];
                    state_d   = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    as_b_d  = 1'b0;
                    state_d = S_ASSERT_AS;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_ASSERT_AS: begin
                if (cnt_q == DS_LAST) begin
                    cnt_d   = '0;
                    ds_b_d  = 1'b0;
                    state_d = S_WAIT_ACK;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_WAIT_ACK: begin
                // BERR outranks DTACK; a BERR cycle never captures read data.
                if (!berr_s_q) begin
                    berr_d      = 1'b1;
                    release_now = 1'b1;
                end else if (!dtack_s_q) begin
                    if (is_read_q) begin
                        rdata_d = vme.vme_data_in;
                    end
                    release_now = 1'b1;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    timeout_d   = 1'b1;
                    release_now = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
                if (release_now) begin
                    cnt_d   = '0;
                    as_b_d  = 1'b1;
                    ds_b_d  = 1'b1;
                    oe_d    = 1'b0;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (dtack_s_q && berr_s_q) begin
                    finish_now = 1'b1;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    timeout_d  = 1'b1;
                    finish_now = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
                if (finish_now) begin
                    cnt_d     = '0;
                    dat_wr_d  = 1'b1;
                    dat_out_d = {14'b0, berr_d, timeout_d, is_read_q ? rdata_q : 16'h0};
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                write_b_d = 1'b1;
                cnt_d     = '0;
                state_d   = S_RECOVER;
            end
            S_RECOVER: begin
                if (cnt_q == RECOV_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Ready is registered alongside the state, so it rises on the same
        // edge the FSM lands in IDLE (including the first edge after reset).
        cmd_rd_d = (state_d == S_IDLE);
    end

    assign vme_cmd_rd       = cmd_rd_q;
    assign vme_dat_wr       = dat_wr_q;
    assign vme_dat_reg_out  = dat_out_q;
    assign vme.vme_addr     = addr_q;
    assign vme.vme_am       = am_q;
    assign vme.vme_as_b     = as_b_q;
    assign vme.vme_ds0_b    = ds_b_q;
    assign vme.vme_ds1_b    = ds_b_q;
    assign vme.vme_write_b  = write_b_q;
    assign vme.vme_lword_b  = 1'b1;
    assign vme.vme_data_out = dout_q;
    assign vme.vme_data_oe  = oe_q;
endmodule

// File: tb/tb_vme_master_seq.sv
// tb/tb_vme_master_seq.sv - self-checking bench for vme_master_seq
module tb_vme_master_seq;
    localparam int SETUP_CYC   = 2;
    localparam int DS_DLY      = 1;
    localparam int TIMEOUT_CYC = 255;
    localparam int RECOV_CYC   = 4;
    localparam int K_ACK  = 0;
    localparam int K_BOTH = 1;
    localparam int K_BERR = 2;
    localparam int K_NONE = 3;

    typedef struct {
        logic [31:0] cmd;
        logic [31:0] din;
        int          kind;
        int          dly;
        logic [15:0] rd;
        logic [31:0] exp_dat;
        logic [22:0] exp_addr;
        logic        exp_wb;
        logic [15:0] exp_dout;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] vme_cmd_reg = '0;
    logic [31:0] vme_dat_reg_in = '0;
    logic        vme_cmd_rd;
    logic        vme_dat_wr;
    logic [31:0] vme_dat_reg_out;

    int          n_tests = 0;
    int          n_fail = 0;
    int          slv_kind = K_NONE;
    int          slv_dly = 0;
    logic [15:0] slv_rd = '0;
    int          ds_cnt = 0;
    vec_t        vecs [8];

    vme_master_seq_if vme ();

    vme_master_seq #(
        .AM_CODE(6'h39), .SETUP_CYC(SETUP_CYC), .DS_DLY(DS_DLY),
        .TIMEOUT_CYC(TIMEOUT_CYC), .RECOV_CYC(RECOV_CYC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .vme_cmd_reg(vme_cmd_reg),
        .vme_dat_reg_in(vme_dat_reg_in), .vme_cmd_rd(vme_cmd_rd),
        .vme_dat_wr(vme_dat_wr), .vme_dat_reg_out(vme_dat_reg_out), .vme(vme)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Slave model: responds slv_dly cycles after DS is first seen low,
    // releases everything as soon as AS is seen high.
    always @(negedge clk) begin
        if (rst || vme.vme_as_b) begin
            vme.vme_dtack_b = 1'b1;
            vme.vme_berr_b  = 1'b1;
            vme.vme_data_in = ~slv_rd;
            ds_cnt = 0;
        end else if (!vme.vme_ds0_b) begin
            if (ds_cnt == slv_dly) begin
                vme.vme_data_in = slv_rd;
                if (slv_kind == K_ACK || slv_kind == K_BOTH) vme.vme_dtack_b = 1'b0;
                if (slv_kind == K_BERR || slv_kind == K_BOTH) vme.vme_berr_b = 1'b0;
            end
            ds_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_dat(input logic [31:0] cmd, input int kind, input logic [15:0] rd);
        if (kind == K_NONE) return 32'h0001_0000;
        if (kind != K_ACK) return 32'h0002_0000;
        return cmd[25] ? {16'h0, rd} : 32'h0;
    endfunction

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!vme_cmd_rd && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, 32'(vme_cmd_rd), 32'd1);
    endtask

    task automatic do_cmd(input string tag, input logic [31:0] cmd, input logic [31:0] din,
                          input int kind, input int dly, input logic [15:0] rd,
                          input logic [31:0] exp_dat, input logic [22:0] exp_addr,
                          input logic exp_wb, input logic [15:0] exp_dout);
        int t, t_as, t_ds, t_dsr, t_wr, t_rd, nwr, exp_hold, exp_rel;
        logic [22:0] c_addr;
        logic [5:0]  c_am;
        logic        c_wb, c_oe, c_lw;
        logic [15:0] c_dout;
        logic [31:0] c_dat, c_hold;
        logic [3:0]  c_strb;
        c_addr = '0; c_am = '0; c_wb = 1'b0; c_oe = 1'b0; c_lw = 1'b0;
        c_dout = '0; c_dat = '0; c_hold = '0; c_strb = '0;
        exp_hold = (kind == K_NONE) ? TIMEOUT_CYC : dly + 3;   // 2-flop sync + registered decision
        exp_rel  = (kind == K_NONE) ? 1 : 3;
        slv_kind = kind; slv_dly = dly; slv_rd = rd;
        wait_ready(tag);
        vme_cmd_reg = cmd; vme_dat_reg_in = din; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_latch_rd_low"}, 32'(vme_cmd_rd), 32'd0);
        t = 0; t_as = -1; t_ds = -1; t_dsr = -1; t_wr = -1; t_rd = -1; nwr = 0;
        while (t < 400 && t_rd < 0) begin
            if (t_as < 0 && !vme.vme_as_b) begin
                t_as = t; c_addr = vme.vme_addr; c_am = vme.vme_am; c_wb = vme.vme_write_b;
                c_dout = vme.vme_data_out; c_oe = vme.vme_data_oe; c_lw = vme.vme_lword_b;
            end
            if (t_ds < 0 && !vme.vme_ds0_b && !vme.vme_ds1_b) t_ds = t;
            if (t_ds >= 0 && t_dsr < 0 && vme.vme_ds0_b && vme.vme_ds1_b) t_dsr = t;
            if (vme_dat_wr) begin
                nwr++;
                if (t_wr < 0) begin
                    t_wr = t; c_dat = vme_dat_reg_out;
                    c_strb = {vme.vme_as_b, vme.vme_ds0_b, vme.vme_ds1_b, vme.vme_data_oe};
                end
            end
            if (t_wr >= 0 && t_rd < 0 && vme_cmd_rd) begin
                t_rd = t; c_hold = vme_dat_reg_out;
            end
            @(negedge clk);
            t++;
        end
        check({tag, "_completed"}, 32'(t_rd >= 0), 32'd1);
        check({tag, "_as_after_latch"}, 32'(t_as), 32'(SETUP_CYC));
        check({tag, "_ds_after_as"}, 32'(t_ds - t_as), 32'(DS_DLY));
        check({tag, "_ds_low_len"}, 32'(t_dsr - t_ds), 32'(exp_hold));
        check({tag, "_release_to_wr"}, 32'(t_wr - t_dsr), 32'(exp_rel));
        check({tag, "_wr_to_ready"}, 32'(t_rd - t_wr), 32'(RECOV_CYC + 1));
        check({tag, "_wr_pulses"}, 32'(nwr), 32'd1);
        check({tag, "_addr"}, 32'(c_addr), 32'(exp_addr));
        check({tag, "_am"}, 32'(c_am), 32'h39);
        check({tag, "_write_b"}, 32'(c_wb), 32'(exp_wb));
        check({tag, "_data_oe"}, 32'(c_oe), 32'(!exp_wb));
        check({tag, "_lword_b"}, 32'(c_lw), 32'd1);
        if (!exp_wb) check({tag, "_data_out"}, 32'(c_dout), 32'(exp_dout));
        check({tag, "_dat_out"}, c_dat, exp_dat);
        check({tag, "_strobes_released"}, 32'(c_strb), 32'hE);
        check({tag, "_dat_out_held"}, c_hold, exp_dat);
    endtask

    initial begin
        int bad, pulses, w1, r1, l2, a2, w2;
        vecs[0] = '{32'h01A83010, 32'h0000BEEF, K_ACK,  3, 16'h0000, 32'h0000_0000, 23'h541808, 1'b0, 16'hBEEF};
        vecs[1] = '{32'h02A84100, 32'hFFFF5555, K_ACK,  0, 16'h1234, 32'h0000_1234, 23'h542080, 1'b1, 16'h0000};
        vecs[2] = '{32'h02A84100, 32'h00000000, K_NONE, 0, 16'hDEAD, 32'h0001_0000, 23'h542080, 1'b1, 16'h0000};
        vecs[3] = '{32'h01A83010, 32'h0000CAFE, K_BOTH, 1, 16'h5A5A, 32'h0002_0000, 23'h541808, 1'b0, 16'hCAFE};
        vecs[4] = '{32'h03000002, 32'h00001111, K_ACK,  2, 16'hA5A5, 32'h0000_A5A5, 23'h000001, 1'b1, 16'h0000};
        vecs[5] = '{32'h02000000, 32'h00000000, K_BERR, 4, 16'h7777, 32'h0002_0000, 23'h000000, 1'b1, 16'h0000};
        vecs[6] = '{32'hFEFFFFFF, 32'h00000000, K_ACK,  1, 16'hFFFF, 32'h0000_FFFF, 23'h7FFFFF, 1'b1, 16'h0000};
        vecs[7] = '{32'hFD000001, 32'hABCD8001, K_ACK,  5, 16'h4321, 32'h0000_0000, 23'h000000, 1'b0, 16'h8001};

        #1 rst = 1'b1;
        #2;
        check("reset_cmd_rd", 32'(vme_cmd_rd), 32'd0);
        check("reset_dat_wr", 32'(vme_dat_wr), 32'd0);
        check("reset_dat_out", vme_dat_reg_out, 32'd0);
        check("reset_addr_am", {3'b0, vme.vme_am, vme.vme_addr}, 32'd0);
        check("reset_strobes", 32'({vme.vme_as_b, vme.vme_ds0_b, vme.vme_ds1_b, vme.vme_write_b, vme.vme_lword_b}), 32'h1F);
        check("reset_data", {15'b0, vme.vme_data_oe, vme.vme_data_out}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_release_rd_low", 32'(vme_cmd_rd), 32'd0);
        @(negedge clk);
        check("rst_release_rd_high", 32'(vme_cmd_rd), 32'd1);

        for (int i = 0; i < 8; i++) begin
            do_cmd($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].din, vecs[i].kind, vecs[i].dly,
                   vecs[i].rd, vecs[i].exp_dat, vecs[i].exp_addr, vecs[i].exp_wb, vecs[i].exp_dout);
        end

        for (int i = 0; i < 40; i++) begin
            logic [31:0] cmd, din;
            logic [15:0] rd;
            int kind, dly;
            cmd = $urandom;
            if (cmd[25:24] == 2'b00) cmd[24] = 1'b1;
            din  = $urandom;
            rd   = 16'($urandom);
            kind = ($urandom_range(0, 9) == 0) ? K_NONE : int'($urandom_range(0, 2));
            dly  = int'($urandom_range(0, 12));
            do_cmd($sformatf("rnd%0d", i), cmd, din, kind, dly, rd,
                   model_dat(cmd, kind, rd), cmd[23:1], cmd[25], din[15:0]);
        end

        // start held high across two commands
        slv_kind = K_ACK; slv_dly = 0;
        wait_ready("b2b");
        vme_cmd_reg = 32'h01000010; vme_dat_reg_in = 32'h00001111; start = 1'b1;
        w1 = -1; r1 = -1; l2 = -1; a2 = -1; w2 = -1;
        for (int t = 0; t < 200 && w2 < 0; t++) begin
            @(negedge clk);
            if (vme_dat_wr && w1 < 0) w1 = t;
            else if (vme_dat_wr && r1 >= 0 && w2 < 0) w2 = t;
            if (w1 >= 0 && r1 < 0 && vme_cmd_rd) r1 = t;
            if (r1 >= 0 && l2 < 0 && !vme_cmd_rd) l2 = t;
            if (l2 >= 0 && a2 < 0 && !vme.vme_as_b) a2 = t;
        end
        start = 1'b0;
        check("b2b_second_done", 32'(w2 >= 0), 32'd1);
        check("b2b_recover_gap", 32'(r1 - w1), 32'(RECOV_CYC + 1));
        check("b2b_ready_one_cycle", 32'(l2 - r1), 32'd1);
        check("b2b_second_as", 32'(a2 - l2), 32'(SETUP_CYC));

        // start with neither direction bit: nothing happens
        wait_ready("inv");
        vme_cmd_reg = 32'h00ABCDEF; start = 1'b1;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (!vme.vme_as_b || !vme_cmd_rd || vme_dat_wr) bad++;
        end
        start = 1'b0;
        check("inv_no_activity", 32'(bad), 32'd0);

        // reset while waiting for DTACK
        slv_kind = K_NONE;
        wait_ready("rst");
        vme_cmd_reg = 32'h02123456; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("rst_pre_ds_low", 32'(vme.vme_ds0_b), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("rst_async_strobes", 32'({vme.vme_as_b, vme.vme_ds0_b, vme.vme_ds1_b}), 32'h7);
        check("rst_async_cmd_rd", 32'(vme_cmd_rd), 32'd0);
        pulses = 0;
        repeat (2) begin
            @(negedge clk);
            if (vme_dat_wr) pulses++;
        end
        rst = 1'b0;
        check("rst_mid_rd_low", 32'(vme_cmd_rd), 32'd0);
        @(negedge clk);
        check("rst_mid_rd_high", 32'(vme_cmd_rd), 32'd1);
        repeat (6) begin
            @(negedge clk);
            if (vme_dat_wr) pulses++;
        end
        check("rst_no_dat_wr", 32'(pulses), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
